// File: rtl/ahb_slave_mem_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and the byte-lane decode
// used by the memory slave.
package ahb_slave_mem_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // state    | meaning
    // ST_IDLE  | no transfer in flight, OKAY, ready
    // ST_WAIT  | OKAY transfer stalled by the wait-state counter
    // ST_DATA  | completing OKAY data phase
    // ST_ERR1  | first ERROR cycle, not ready
    // ST_ERR2  | second ERROR cycle, ready
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ahb_slv_state_e;

    function automatic logic [3:0] be_decode(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << off;
            HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// Word-organised storage: byte-enable synchronous write, asynchronous read,
// contents are never reset.
module ahb_slave_mem_array #(
    parameter int MEM_DEPTH = 256,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: address-phase capture, wait-state / ERROR response
// FSM and byte-lane writes into ahb_slave_mem_array.
module ahb_slave_mem
    import ahb_slave_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hreset_n,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata
);

    localparam int              AW         = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W+1)'(MEM_DEPTH * 4);
    localparam bit              HAS_WAIT   = (WAIT_STATES > 0);
    localparam logic [3:0]      WAIT_LOAD  = 4'(HAS_WAIT ? WAIT_STATES - 1 : 0);

    ahb_slv_state_e r_state;
    logic [3:0]     r_cnt;
    logic [AW+1:0]  r_addr;
    logic           r_write;
    logic [2:0]     r_size;
    logic           r_hreadyout;
    logic           r_hresp;

    logic           w_accept;
    logic           w_err;
    logic           w_we;
    logic [3:0]     w_be;
    logic [31:0]    w_rdata;
    logic           w_unused;

    assign w_unused = &{1'b0, htrans[0], hburst};

    // Only sample a new address phase while the slave itself reports ready.
    assign w_accept = hsel & hready & htrans[1] & r_hreadyout;

    always_comb begin
        w_err = 1'b0;
        if (hsize > HSIZE_WORD)                             w_err = 1'b1;
        if ((hsize == HSIZE_HALF) && haddr[0])              w_err = 1'b1;
        if ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00)) w_err = 1'b1;
        if ({1'b0, haddr} >= BYTE_LIMIT)                    w_err = 1'b1;
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_size      <= HSIZE_BYTE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= ST_DATA;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    // IDLE, DATA and ERR2 are all ready cycles sharing the accept rule.
                    if (w_accept) begin
                        r_addr  <= haddr[AW+1:0];
                        r_write <= hwrite;
                        r_size  <= hsize;
                        if (w_err) begin
                            r_state     <= ST_ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= HRESP_ERROR;
                        end else if (HAS_WAIT) begin
                            r_state     <= ST_WAIT;
                            r_cnt       <= WAIT_LOAD;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= HRESP_OKAY;
                        end else begin
                            r_state     <= ST_DATA;
                            r_hreadyout <= 1'b1;
                            r_hresp     <= HRESP_OKAY;
                        end
                    end else begin
                        r_state     <= ST_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    assign w_we = (r_state == ST_DATA) && r_write;
    assign w_be = be_decode(r_size, r_addr[1:0]);

    ahb_slave_mem_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_array (
        .clk     (hclk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (r_addr[AW+1:2]),
        .i_wdata (hwdata),
        .o_rdata (w_rdata)
    );

    assign hreadyout = r_hreadyout;
    assign hresp     = r_hresp;
    assign hrdata    = (r_state == ST_DATA) ? w_rdata : '0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: a zero-wait and a three-wait instance,
// each acting as the only slave on its fabric (hready = own hreadyout).
module tb_ahb_slave_mem;

    logic        clk = 1'b0;
    logic        hreset_n;
    logic        hsel0, hsel3;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        ro0, resp0, ro3, resp3;
    logic [31:0] rd0, rd3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ahb_slave_mem #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .hclk(clk), .hreset_n(hreset_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(ro0),
        .hreadyout(ro0), .hresp(resp0), .hrdata(rd0)
    );

    ahb_slave_mem #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
        .hclk(clk), .hreset_n(hreset_n), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(ro3),
        .hreadyout(ro3), .hresp(resp3), .hrdata(rd3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ap(input logic s0, input logic s3, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] a);
        hsel0  = s0;
        hsel3  = s3;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
    endtask

    task automatic idle();
        ap(1'b0, 1'b0, 2'd0, 1'b0, 3'd2, 32'h0);
    endtask

    initial begin
        hreset_n = 1'b0;
        hburst   = 3'd0;
        hwdata   = 32'h0;
        idle();
        repeat (3) step();
        chk("rst ready0", {31'd0, ro0}, 32'd1);
        chk("rst resp0", {31'd0, resp0}, 32'd0);
        chk("rst rdata0", rd0, 32'h0);
        chk("rst ready3", {31'd0, ro3}, 32'd1);
        chk("rst resp3", {31'd0, resp3}, 32'd0);
        chk("rst rdata3", rd3, 32'h0);
        #3 hreset_n = 1'b1;
        step();

        // zero-wait write then back-to-back read of 0x10
        ap(1, 0, 2'd2, 1, 3'd2, 32'h10);
        step();
        hwdata = 32'hDEADBEEF;
        chk("zw write ready", {31'd0, ro0}, 32'd1);
        ap(1, 0, 2'd2, 0, 3'd2, 32'h10);
        step();
        chk("zw read ready", {31'd0, ro0}, 32'd1);
        chk("zw read data", rd0, 32'hDEADBEEF);
        chk("zw read resp", {31'd0, resp0}, 32'd0);
        idle();
        step();
        chk("zw idle ready", {31'd0, ro0}, 32'd1);
        chk("zw idle rdata gated", rd0, 32'h0);

        // byte and halfword lanes on word 0
        ap(1, 0, 2'd2, 1, 3'd2, 32'h0);
        step();
        hwdata = 32'h0;
        ap(1, 0, 2'd3, 1, 3'd0, 32'h3);
        step();
        hwdata = 32'hAAFFFFFF;
        ap(1, 0, 2'd3, 1, 3'd1, 32'h0);
        step();
        hwdata = 32'hFFFF1234;
        ap(1, 0, 2'd2, 0, 3'd2, 32'h0);
        step();
        chk("lanes data", rd0, 32'hAA001234);
        chk("lanes ready", {31'd0, ro0}, 32'd1);
        idle();
        step();

        // BUSY and IDLE with hsel high: zero-wait OKAY, no write
        ap(1, 0, 2'd1, 1, 3'd2, 32'h0);
        step();
        hwdata = 32'h0BADF00D;
        chk("busy ready", {31'd0, ro0}, 32'd1);
        chk("busy resp", {31'd0, resp0}, 32'd0);
        chk("busy rdata", rd0, 32'h0);
        ap(1, 0, 2'd0, 1, 3'd2, 32'h0);
        step();
        chk("idle ready", {31'd0, ro0}, 32'd1);
        chk("idle resp", {31'd0, resp0}, 32'd0);
        ap(1, 0, 2'd2, 0, 3'd2, 32'h0);
        step();
        chk("busy/idle no write", rd0, 32'hAA001234);
        idle();
        step();

        // misaligned word read -> two-cycle ERROR
        ap(1, 0, 2'd2, 0, 3'd2, 32'h2);
        step();
        idle();
        chk("mis err1 ready", {31'd0, ro0}, 32'd0);
        chk("mis err1 resp", {31'd0, resp0}, 32'd1);
        chk("mis err1 rdata", rd0, 32'h0);
        step();
        chk("mis err2 ready", {31'd0, ro0}, 32'd1);
        chk("mis err2 resp", {31'd0, resp0}, 32'd1);
        step();
        chk("mis after ready", {31'd0, ro0}, 32'd1);
        chk("mis after resp", {31'd0, resp0}, 32'd0);

        // out-of-range write aliasing onto word 0 must not write
        ap(1, 0, 2'd2, 1, 3'd2, 32'h400);
        step();
        hwdata = 32'h99999999;
        idle();
        chk("oor err1 ready", {31'd0, ro0}, 32'd0);
        chk("oor err1 resp", {31'd0, resp0}, 32'd1);
        step();
        chk("oor err2 ready", {31'd0, ro0}, 32'd1);
        chk("oor err2 resp", {31'd0, resp0}, 32'd1);
        ap(1, 0, 2'd2, 0, 3'd2, 32'h0);
        step();
        chk("oor word0 kept", rd0, 32'hAA001234);
        chk("oor read resp", {31'd0, resp0}, 32'd0);
        idle();
        step();

        // three wait states: write then read 0x20
        ap(0, 1, 2'd2, 1, 3'd2, 32'h20);
        step();
        hwdata = 32'hCAFEF00D;
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("ws write wait", {31'd0, ro3}, 32'd0);
            step();
        end
        chk("ws write done", {31'd0, ro3}, 32'd1);
        ap(0, 1, 2'd2, 0, 3'd2, 32'h20);
        step();
        idle();
        hwdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("ws read wait", {31'd0, ro3}, 32'd0);
            chk("ws read resp", {31'd0, resp3}, 32'd0);
            step();
        end
        chk("ws read ready", {31'd0, ro3}, 32'd1);
        chk("ws read data", rd3, 32'hCAFEF00D);
        chk("ws read okay", {31'd0, resp3}, 32'd0);
        step();
        chk("ws idle ready", {31'd0, ro3}, 32'd1);
        chk("ws idle rdata", rd3, 32'h0);

        // ERROR length is independent of wait states
        ap(0, 1, 2'd2, 0, 3'd1, 32'h21);
        step();
        idle();
        chk("ws err1 ready", {31'd0, ro3}, 32'd0);
        chk("ws err1 resp", {31'd0, resp3}, 32'd1);
        step();
        chk("ws err2 ready", {31'd0, ro3}, 32'd1);
        chk("ws err2 resp", {31'd0, resp3}, 32'd1);
        step();
        chk("ws err done", {31'd0, resp3}, 32'd0);

        // reset during the WAIT of a write drops the write
        ap(0, 1, 2'd2, 1, 3'd2, 32'h20);
        step();
        hwdata = 32'h11111111;
        idle();
        chk("rstmid wait1", {31'd0, ro3}, 32'd0);
        step();
        chk("rstmid wait2", {31'd0, ro3}, 32'd0);
        hreset_n = 1'b0;
        #1;
        chk("rstmid ready", {31'd0, ro3}, 32'd1);
        chk("rstmid resp", {31'd0, resp3}, 32'd0);
        chk("rstmid rdata", rd3, 32'h0);
        step();
        #3 hreset_n = 1'b1;
        step();
        ap(0, 1, 2'd2, 0, 3'd2, 32'h20);
        step();
        idle();
        repeat (3) step();
        chk("rstmid post ready", {31'd0, ro3}, 32'd1);
        chk("rstmid word kept", rd3, 32'hCAFEF00D);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
